// File: rtl/stage_memory_access_pkg.sv
// rtl/stage_memory_access_pkg.sv - memory-stage op/state types and lane helpers
package mem_access_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8,
        OP_LL   = 4'd9,
        OP_SC   = 4'd10
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESP   = 2'd3
    } mem_state_t;

    function automatic logic is_store(input mem_op_t op);
        return op inside {OP_SB, OP_SH, OP_SW, OP_SC};
    endfunction

    function automatic logic is_load(input mem_op_t op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL};
    endfunction

    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU, OP_SH:       return lo[0];
            OP_LW, OP_SW, OP_LL, OP_SC: return |lo;
            default:                    return 1'b0;
        endcase
    endfunction

    // Loads drive the same lane enables as the matching store width.
    function automatic logic [3:0] lane_be(input mem_op_t op, input logic [1:0] lo);
        case (op)
            OP_LB, OP_LBU, OP_SB:       return 4'b0001 << lo;
            OP_LH, OP_LHU, OP_SH:       return lo[1] ? 4'b1100 : 4'b0011;
            OP_LW, OP_SW, OP_LL, OP_SC: return 4'b1111;
            default:                    return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input mem_op_t op, input logic [31:0] d);
        case (op)
            OP_SB:        return {4{d[7:0]}};
            OP_SH:        return {2{d[15:0]}};
            OP_SW, OP_SC: return d;
            default:      return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/stage_memory_access_if.sv
// rtl/stage_memory_access_if.sv - data-bus request/ack interface
interface stage_memory_access_if;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/stage_memory_access_load_align.sv
// rtl/stage_memory_access_load_align.sv - byte/half extraction and extension of a read word
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  mem_op_t     op,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        data = 32'd0;
        case (op)
            OP_LB:        data = {{24{byte_v[7]}}, byte_v};
            OP_LBU:       data = {24'd0, byte_v};
            OP_LH:        data = {{16{half_v[15]}}, half_v};
            OP_LHU:       data = {16'd0, half_v};
            OP_LW, OP_LL: data = rdata;
            default:      data = 32'd0;
        endcase
    end

endmodule

// File: rtl/stage_memory_access.sv
// rtl/stage_memory_access.sv - memory-stage load/store engine with LL/SC link bit
module stage_memory_access
    import mem_access_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  mem_op_t                       mem_op,
    input  logic [31:0]                   addr,
    input  logic [31:0]                   store_data,
    input  logic                          nullify,
    input  logic                          eret,
    stage_memory_access_if.master         bus,
    output logic [31:0]                   load_data,
    output logic                          done,
    output logic                          busy,
    output logic                          addr_error,
    output logic                          llbit
);

    mem_state_t  state_q, state_d;
    mem_op_t     op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        done_q, done_d;
    logic        addr_error_q, addr_error_d;
    logic        llbit_q, llbit_d;
    logic [31:0] lladdr_q, lladdr_d;

    logic        accept;
    logic        release_bus;
    logic [31:0] aligned;

    load_align u_load_align (
        .rdata   (bus.bus_rdata),
        .addr_lo (addr_q[1:0]),
        .op      (op_q),
        .data    (aligned)
    );

    assign accept = (state_q == ST_IDLE) && start && (mem_op != OP_NONE) && !nullify;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_be_d     = bus_be_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        load_data_d  = load_data_q;
        done_d       = 1'b0;
        addr_error_d = 1'b0;
        llbit_d      = llbit_q;
        lladdr_d     = lladdr_q;
        release_bus  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_misaligned(mem_op, addr[1:0])) begin
                        state_d      = ST_RESP;
                        addr_error_d = 1'b1;
                        load_data_d  = 32'd0;
                    end else if (mem_op == OP_SC && !llbit_q) begin
                        // Failed SC never touches the bus.
                        state_d     = ST_RESP;
                        done_d      = 1'b1;
                        load_data_d = 32'd0;
                    end else begin
                        state_d     = ST_ACCESS;
                        op_d        = mem_op;
                        addr_d      = addr;
                        bus_req_d   = 1'b1;
                        bus_we_d    = is_store(mem_op);
                        bus_be_d    = lane_be(mem_op, addr[1:0]);
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_wdata_d = lane_wdata(mem_op, store_data);
                    end
                end
            end
            ST_ACCESS: begin
                if (nullify) begin
                    // A flushed access still has to finish on the bus before we let go.
                    release_bus = bus.bus_ack;
                    state_d     = bus.bus_ack ? ST_IDLE : ST_DRAIN;
                end else if (bus.bus_ack) begin
                    release_bus = 1'b1;
                    done_d      = 1'b1;
                    state_d     = ST_RESP;
                    if (op_q == OP_SC) begin
                        load_data_d = 32'd1;
                    end else if (is_load(op_q)) begin
                        load_data_d = aligned;
                    end else begin
                        load_data_d = 32'd0;
                    end
                    if (op_q == OP_LL) begin
                        llbit_d  = 1'b1;
                        lladdr_d = addr_q;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.bus_ack) begin
                    release_bus = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (release_bus) begin
            bus_req_d   = 1'b0;
            bus_we_d    = 1'b0;
            bus_be_d    = 4'd0;
            bus_addr_d  = 32'd0;
            bus_wdata_d = 32'd0;
        end

        // eret wins over a same-cycle LL completion.
        if (eret) begin
            llbit_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_NONE;
            addr_q       <= 32'd0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_be_q     <= 4'd0;
            bus_addr_q   <= 32'd0;
            bus_wdata_q  <= 32'd0;
            load_data_q  <= 32'd0;
            done_q       <= 1'b0;
            addr_error_q <= 1'b0;
            llbit_q      <= 1'b0;
            lladdr_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_be_q     <= bus_be_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            load_data_q  <= load_data_d;
            done_q       <= done_d;
            addr_error_q <= addr_error_d;
            llbit_q      <= llbit_d;
            lladdr_q     <= lladdr_d;
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign load_data     = load_data_q;
    assign done          = done_q;
    assign addr_error    = addr_error_q;
    assign llbit         = llbit_q;
    assign busy          = accept || (state_q == ST_ACCESS) || (state_q == ST_DRAIN);

endmodule
